wb_gather: RTL and testbench

WB_GATHER -- requirements
Module: wb_gather

---
 rtl/wb_pkg.sv | 24 ++
 rtl/vec_beat_collector.sv | 31 +++
 rtl/wb_gather.sv | 126 ++++++++++++
 tb/tb_wb_gather.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared widths, state encoding and latched-command payload for the write-back gather stage.
package wb_pkg;

  localparam int unsigned VEC_W  = 256;
  localparam int unsigned LANE_W = 32;
  localparam int unsigned LANES  = 8;
  localparam int unsigned CNT_W  = $clog2(LANES);
  localparam int unsigned RD_W   = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATHER = 2'd1,
    COMMIT = 2'd2
  } wb_state_t;

  // Instruction fields captured at acceptance
  typedef struct packed {
    logic            vec;
    logic            scal;
    logic            sel;
    logic [RD_W-1:0] rd;
  } wb_cmd_t;

endpackage

// File: rtl/vec_beat_collector.sv
// Lane register array and beat counter; assembles memory beats into a vector.
module vec_beat_collector
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              beat_valid,
  input  logic [LANE_W-1:0] beat_data,
  output logic [VEC_W-1:0]  lanes,
  output logic [CNT_W-1:0]  count
);

  logic [LANES-1:0][LANE_W-1:0] lane_q;

  // Counter wraps naturally from LANES-1 back to 0
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      count  <= '0;
    end else if (clear) begin
      count  <= '0;
    end else if (beat_valid) begin
      lane_q[count] <= beat_data;
      count         <= count + CNT_W'(1);
    end
  end

  assign lanes = lane_q;

endmodule

// File: rtl/wb_gather.sv
// Write-back stage: commits ALU results directly or gathers memory beats into a
// scalar/vector write before issuing a one-cycle register-file strobe.
module wb_gather
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              WriteRegister_M,
  input  logic              WriteRegisterVec_M,
  input  logic              SelWriteData_M,
  input  logic [RD_W-1:0]   rd_M,
  input  logic [VEC_W-1:0]  alu_result_M,
  input  logic [LANE_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_req,
  output logic [CNT_W-1:0]  mem_beat,
  output logic              stall,
  output logic              WRITEREGISTER_WB,
  output logic              WRITEREGISTERVEC_WB,
  output logic [RD_W-1:0]   RD_WB,
  output logic [VEC_W-1:0]  INPUTDATA
);

  wb_state_t        state_q, state_d;
  wb_cmd_t          cmd_q, cmd_d;
  logic             wr_d, wrv_d, mem_req_d;
  logic [RD_W-1:0]  rd_d;
  logic [VEC_W-1:0] data_d;

  logic             accept_c;
  logic             beat_take_c;
  logic             last_beat_c;
  logic             clear_c;
  logic [VEC_W-1:0] lanes;
  logic [CNT_W-1:0] count;
  logic [VEC_W-1:0] gathered_c;

  assign in_ready    = (state_q == IDLE);
  assign stall       = ~in_ready;
  assign mem_beat    = count;
  assign accept_c    = in_valid && in_ready;
  assign beat_take_c = (state_q == GATHER) && mem_rvalid;
  assign last_beat_c = beat_take_c && cmd_q.sel &&
                       (cmd_q.vec ? (count == CNT_W'(LANES - 1)) : 1'b1);

  // The final vector beat lands in the top lane, so merge it directly
  assign gathered_c = cmd_q.vec ? {mem_rdata, lanes[VEC_W-LANE_W-1:0]}
                                : VEC_W'(mem_rdata);

  vec_beat_collector u_collector (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear_c),
    .beat_valid (beat_take_c),
    .beat_data  (mem_rdata),
    .lanes      (lanes),
    .count      (count)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    wr_d    = 1'b0;
    wrv_d   = 1'b0;
    rd_d    = RD_WB;
    data_d  = INPUTDATA;
    clear_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          cmd_d.vec  = WriteRegisterVec_M;
          cmd_d.scal = WriteRegister_M;
          cmd_d.sel  = SelWriteData_M;
          cmd_d.rd   = rd_M;
          if (WriteRegisterVec_M || WriteRegister_M) begin
            if (SelWriteData_M) begin
              state_d = GATHER;
              clear_c = 1'b1;
            end else begin
              state_d = COMMIT;
              wrv_d   = WriteRegisterVec_M;
              wr_d    = WriteRegister_M && !WriteRegisterVec_M;
              rd_d    = rd_M;
              data_d  = alu_result_M;
            end
          end
        end
      end
      GATHER: begin
        if (last_beat_c) begin
          state_d = COMMIT;
          wrv_d   = cmd_q.vec;
          wr_d    = cmd_q.scal && !cmd_q.vec;
          rd_d    = cmd_q.rd;
          data_d  = gathered_c;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mem_req_d = (state_d == GATHER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= IDLE;
      cmd_q               <= '0;
      mem_req             <= 1'b0;
      WRITEREGISTER_WB    <= 1'b0;
      WRITEREGISTERVEC_WB <= 1'b0;
      RD_WB               <= '0;
      INPUTDATA           <= '0;
    end else begin
      state_q             <= state_d;
      cmd_q               <= cmd_d;
      mem_req             <= mem_req_d;
      WRITEREGISTER_WB    <= wr_d;
      WRITEREGISTERVEC_WB <= wrv_d;
      RD_WB               <= rd_d;
      INPUTDATA           <= data_d;
    end
  end

endmodule

// File: tb/tb_wb_gather.sv
// Randomized scoreboard bench for wb_gather with directed corner cases.
module tb_wb_gather;
  import wb_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              WriteRegister_M = 1'b0;
  logic              WriteRegisterVec_M = 1'b0;
  logic              SelWriteData_M = 1'b0;
  logic [4:0]        rd_M = '0;
  logic [255:0]      alu_result_M = '0;
  logic [31:0]       mem_rdata;
  logic              mem_rvalid;
  logic              mem_req;
  logic [2:0]        mem_beat;
  logic              stall;
  logic              WRITEREGISTER_WB;
  logic              WRITEREGISTERVEC_WB;
  logic [4:0]        RD_WB;
  logic [255:0]      INPUTDATA;

  wb_gather dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .WriteRegister_M     (WriteRegister_M),
    .WriteRegisterVec_M  (WriteRegisterVec_M),
    .SelWriteData_M      (SelWriteData_M),
    .rd_M                (rd_M),
    .alu_result_M        (alu_result_M),
    .mem_rdata           (mem_rdata),
    .mem_rvalid          (mem_rvalid),
    .mem_req             (mem_req),
    .mem_beat            (mem_beat),
    .stall               (stall),
    .WRITEREGISTER_WB    (WRITEREGISTER_WB),
    .WRITEREGISTERVEC_WB (WRITEREGISTERVEC_WB),
    .RD_WB               (RD_WB),
    .INPUTDATA           (INPUTDATA)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         vec;
    logic         scal;
    logic [4:0]   rd;
    logic [255:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] beat_q[$];
  int          idx_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          resp_en = 1'b0;
  bit          alt_gap = 1'b0;
  bit          gap_ph = 1'b0;
  bit          drove = 1'b0;
  logic        r_valid = 1'b0;
  logic [31:0] r_data = '0;
  logic        man_valid = 1'b0;
  logic [31:0] man_data = '0;
  logic [4:0]  last_rd = '0;
  logic [255:0] last_data = '0;
  exp_t        mon_e;

  assign mem_rvalid = resp_en ? r_valid : man_valid;
  assign mem_rdata  = resp_en ? r_data  : man_data;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: pops the scoreboard on every strobe, otherwise checks hold behaviour
  always @(negedge clk) begin
    if (rst) begin
      last_rd   = '0;
      last_data = '0;
    end else begin
      check("stall_vs_ready", stall, !in_ready);
      if (WRITEREGISTER_WB || WRITEREGISTERVEC_WB) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got scal=%0b vec=%0b expected none", WRITEREGISTER_WB, WRITEREGISTERVEC_WB);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_vec", WRITEREGISTERVEC_WB, mon_e.vec);
          check("strobe_scal", WRITEREGISTER_WB, mon_e.scal);
          check("rd_wb", RD_WB, mon_e.rd);
          check("inputdata", INPUTDATA, mon_e.data);
          last_rd   = mon_e.rd;
          last_data = mon_e.data;
        end
      end else begin
        check("rd_hold", RD_WB, last_rd);
        check("data_hold", INPUTDATA, last_data);
      end
    end
  end

  // Memory responder: serves queued beats while requested, noise otherwise
  always @(negedge clk) begin
    if (resp_en) begin
      if (drove) begin
        beat_q.delete(0);
        idx_q.delete(0);
        drove = 1'b0;
      end
      if (mem_req && beat_q.size() > 0) begin
        check("mem_beat", mem_beat, idx_q[0]);
        if (alt_gap) begin
          r_valid = gap_ph;
          gap_ph  = ~gap_ph;
        end else begin
          r_valid = ($urandom_range(0, 2) != 0);
        end
        r_data = r_valid ? beat_q[0] : $urandom;
        drove  = r_valid;
      end else begin
        r_valid = ($urandom_range(0, 3) == 0);
        r_data  = $urandom;
      end
    end else begin
      r_valid = 1'b0;
      drove   = 1'b0;
    end
  end

  task automatic issue(input logic wr, input logic vec, input logic sel, input logic [4:0] rd,
                       input logic [255:0] alu, input bit fixed, input logic [31:0] base);
    int   n = 0;
    exp_t e;
    logic [31:0] b;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got in_ready=0 expected 1 within 200 cycles");
      return;
    end
    in_valid           = 1'b1;
    WriteRegister_M    = wr;
    WriteRegisterVec_M = vec;
    SelWriteData_M     = sel;
    rd_M               = rd;
    alu_result_M       = alu;
    if (wr || vec) begin
      e.vec  = vec;
      e.scal = wr && !vec;
      e.rd   = rd;
      e.data = '0;
      if (!sel) begin
        e.data = alu;
      end else begin
        for (int k = 0; k < (vec ? 8 : 1); k++) begin
          b = fixed ? 32'(base + 32'(k)) : $urandom;
          beat_q.push_back(b);
          idx_q.push_back(k);
          e.data[32*k +: 32] = b;
        end
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid           = 1'b0;
    WriteRegister_M    = 1'($urandom);
    WriteRegisterVec_M = 1'($urandom);
    SelWriteData_M     = 1'($urandom);
    rd_M               = 5'($urandom);
    alu_result_M       = rand256();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_scal", WRITEREGISTER_WB, 0);
    check("rst_vec", WRITEREGISTERVEC_WB, 0);
    check("rst_rd", RD_WB, 0);
    check("rst_data", INPUTDATA, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_beat", mem_beat, 0);
    resp_en = 1'b1;

    // ALU scalar write with one-cycle latency
    issue(1'b1, 1'b0, 1'b0, 5'd3, 256'h1234, 1'b0, 32'h0);
    @(negedge clk);
    check("alu_strobe", WRITEREGISTER_WB, 1);
    check("alu_rd", RD_WB, 3);
    check("alu_data", INPUTDATA[31:0], 32'h1234);
    @(negedge clk);
    check("alu_one_cycle", WRITEREGISTER_WB, 0);
    check("alu_ready_back", in_ready, 1);

    // Vector load with alternating beat gaps, stall held throughout
    alt_gap = 1'b1;
    issue(1'b0, 1'b1, 1'b1, 5'd7, rand256(), 1'b1, 32'h0);
    n = 0;
    do begin
      @(negedge clk);
      check("vec_stall", stall, 1);
      n++;
    end while (!WRITEREGISTERVEC_WB && n < 100);
    check("vec_commit_seen", WRITEREGISTERVEC_WB, 1);
    @(negedge clk);
    check("vec_ready_back", in_ready, 1);
    alt_gap = 1'b0;

    // Scalar memory load
    issue(1'b1, 1'b0, 1'b1, 5'd5, rand256(), 1'b1, 32'hDEADBEEF);
    wait_idle();

    // Both flags, ALU source: vector wins
    issue(1'b1, 1'b1, 1'b0, 5'd12, rand256(), 1'b0, 32'h0);

    // Neither flag: accepted, no gather, no strobe
    issue(1'b0, 1'b0, 1'b1, 5'd20, rand256(), 1'b0, 32'h0);
    @(negedge clk);
    check("none_ready", in_ready, 1);
    check("none_mem_req", mem_req, 0);
    wait_idle();

    // Reset after five beats of a vector load
    resp_en = 1'b0;
    @(negedge clk);
    in_valid           = 1'b1;
    WriteRegister_M    = 1'b0;
    WriteRegisterVec_M = 1'b1;
    SelWriteData_M     = 1'b1;
    rd_M               = 5'd9;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      man_valid = 1'b1;
      man_data  = 32'hA0 + 32'(k);
      @(negedge clk);
      man_valid = 1'b0;
    end
    check("abort_beat_cnt", mem_beat, 5);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_idle", in_ready, 1);
    check("abort_beat_zero", mem_beat, 0);
    check("abort_mem_req", mem_req, 0);
    check("abort_no_vec", WRITEREGISTERVEC_WB, 0);
    resp_en = 1'b1;
    issue(1'b0, 1'b1, 1'b1, 5'd9, rand256(), 1'b0, 32'h0);
    wait_idle();

    // Randomized mix
    for (int i = 0; i < 60; i++) begin
      issue(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), rand256(), 1'b0, 32'h0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
